// File: rtl/cmd_byte_fifo.sv
// cmd_byte_fifo: show-ahead command-byte FIFO between the serial receiver and control_unit.
// Define CMD_FIFO_ALMOST_FULL_EN to get a registered almost_full backpressure flag.
module cmd_byte_fifo #(
    parameter int DEPTH              = 16,
    parameter int ALMOST_FULL_MARGIN = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    input  logic                     flush,
    output logic [7:0]               out_byte,
    output logic                     out_ready,
    input  logic                     next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ALMOST_FULL_MARGIN < 1 || ALMOST_FULL_MARGIN >= DEPTH) begin : g_param_check
        $error("cmd_byte_fifo: illegal DEPTH or ALMOST_FULL_MARGIN");
    end

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_count_nxt;

    assign w_full      = r_count == CW'(DEPTH);
    assign w_empty     = r_count == '0;
    assign w_pop       = next && !w_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign w_push      = rx_valid && (!w_full || w_pop);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr    <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_count     <= w_count_nxt;
            r_overflow  <= r_overflow || (rx_valid && !w_push);
            r_underflow <= next && w_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= rx_byte;
    end

`ifdef CMD_FIFO_ALMOST_FULL_EN
    logic r_almost_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     r_almost_full <= 1'b0;
        else if (flush) r_almost_full <= 1'b0;
        else            r_almost_full <= w_count_nxt >= CW'(DEPTH - ALMOST_FULL_MARGIN);
    end

    assign almost_full = r_almost_full;
`else
    assign almost_full = 1'b0;
`endif

    assign out_byte  = r_mem[r_rd_ptr];
    assign out_ready = !w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
endmodule

// File: tb/tb_cmd_byte_fifo.sv
// tb_cmd_byte_fifo: directed self-checking bench for cmd_byte_fifo (DEPTH=16, margin 4).
module tb_cmd_byte_fifo;
`ifdef CMD_FIFO_ALMOST_FULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       flush;
    logic [7:0] out_byte;
    logic       out_ready;
    logic       next;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       almost_full;

    int n_pass  = 0;
    int n_total = 0;

    cmd_byte_fifo #(.DEPTH(16), .ALMOST_FULL_MARGIN(4)) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid), .flush(flush),
        .out_byte(out_byte), .out_ready(out_ready), .next(next), .count(count),
        .overflow(overflow), .underflow(underflow), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        n_total++; if (out_ready !== 1'b0) $display("FAIL reset_out_ready: got %b expected 0", out_ready); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
        n_total++; if (underflow !== 1'b0) $display("FAIL reset_underflow: got %b expected 0", underflow); else n_pass++;
        n_total++; if (almost_full !== 1'b0) $display("FAIL reset_almost_full: got %b expected 0", almost_full); else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        push(8'h01);
        n_total++; if (out_ready !== 1'b1) $display("FAIL basic_ready: got %b expected 1", out_ready); else n_pass++;
        n_total++; if (out_byte !== 8'h01) $display("FAIL basic_byte: got %h expected 01", out_byte); else n_pass++;
        n_total++; if (count !== 5'd1) $display("FAIL basic_count: got %0d expected 1", count); else n_pass++;
        next = 1'b1;
        tick();
        next = 1'b0;
        n_total++; if (out_ready !== 1'b0) $display("FAIL basic_pop_ready: got %b expected 0", out_ready); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL basic_pop_count: got %0d expected 0", count); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        n_total++; if (count !== 5'd16) $display("FAIL ovf_fill_count: got %0d expected 16", count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_fill_flag: got %b expected 0", overflow); else n_pass++;
        push(8'hAA);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_drop_flag: got %b expected 1", overflow); else n_pass++;
        n_total++; if (count !== 5'd16) $display("FAIL ovf_drop_count: got %0d expected 16", count); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_total++; if (out_byte !== 8'h10 + 8'(i)) $display("FAIL ovf_drain[%0d]: got %h expected %h", i, out_byte, 8'h10 + 8'(i)); else n_pass++;
            next = 1'b1;
            tick();
            next = 1'b0;
        end
        n_total++; if (out_ready !== 1'b0) $display("FAIL ovf_empty_ready: got %b expected 0", out_ready); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else n_pass++;
        do_flush();
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_flush_clear: got %b expected 0", overflow); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        rx_byte = 8'h55; rx_valid = 1'b1; next = 1'b1;
        tick();
        rx_valid = 1'b0; next = 1'b0;
        n_total++; if (count !== 5'd16) $display("FAIL fpp_count: got %0d expected 16", count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL fpp_overflow: got %b expected 0", overflow); else n_pass++;
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 16) ? 8'h55 : 8'h20 + 8'(i);
            n_total++; if (out_byte !== exp_b) $display("FAIL fpp_drain[%0d]: got %h expected %h", i, out_byte, exp_b); else n_pass++;
            next = 1'b1;
            tick();
            next = 1'b0;
        end
        n_total++; if (count !== 5'd0) $display("FAIL fpp_end_count: got %0d expected 0", count); else n_pass++;
    endtask

    task automatic test_underflow();
        next = 1'b1;
        tick();
        next = 1'b0;
        n_total++; if (underflow !== 1'b1) $display("FAIL unf_pulse: got %b expected 1", underflow); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL unf_count: got %0d expected 0", count); else n_pass++;
        tick();
        n_total++; if (underflow !== 1'b0) $display("FAIL unf_single: got %b expected 0", underflow); else n_pass++;
        rx_byte = 8'h33; rx_valid = 1'b1; next = 1'b1;
        tick();
        rx_valid = 1'b0; next = 1'b0;
        n_total++; if (count !== 5'd1) $display("FAIL unf_push_count: got %0d expected 1", count); else n_pass++;
        n_total++; if (out_byte !== 8'h33) $display("FAIL unf_push_byte: got %h expected 33", out_byte); else n_pass++;
        n_total++; if (underflow !== 1'b1) $display("FAIL unf_push_pulse: got %b expected 1", underflow); else n_pass++;
        tick();
        n_total++; if (underflow !== 1'b0) $display("FAIL unf_push_single: got %b expected 0", underflow); else n_pass++;
        next = 1'b1;
        tick();
        next = 1'b0;
    endtask

    task automatic test_wrap_reset();
        logic [7:0] q[$];
        for (int i = 0; i < 20; i++) begin
            if (q.size() != 0) begin
                n_total++; if (out_byte !== q[0]) $display("FAIL wrap_head[%0d]: got %h expected %h", i, out_byte, q[0]); else n_pass++;
            end
            rx_byte = 8'h40 + 8'(i); rx_valid = 1'b1; next = i[0];
            if (next && q.size() != 0) void'(q.pop_front());
            q.push_back(rx_byte);
            tick();
        end
        rx_valid = 1'b0; next = 1'b0;
        n_total++; if (count !== 5'(q.size())) $display("FAIL wrap_count: got %0d expected %0d", count, q.size()); else n_pass++;
        n_total++; if (out_byte !== q[0]) $display("FAIL wrap_final_head: got %h expected %h", out_byte, q[0]); else n_pass++;
        rx_byte = 8'h77; rx_valid = 1'b1;
        #1 reset = 1'b0;
        #1;
        n_total++; if (count !== 5'd0) $display("FAIL async_count: got %0d expected 0", count); else n_pass++;
        n_total++; if (out_ready !== 1'b0) $display("FAIL async_ready: got %b expected 0", out_ready); else n_pass++;
        rx_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_total++; if (out_ready !== 1'b0) $display("FAIL release_ready: got %b expected 0", out_ready); else n_pass++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        n_total++; if (count !== 5'd5) $display("FAIL flush_pre_count: got %0d expected 5", count); else n_pass++;
        rx_byte = 8'h99; rx_valid = 1'b1; next = 1'b1; flush = 1'b1;
        tick();
        rx_valid = 1'b0; next = 1'b0; flush = 1'b0;
        n_total++; if (count !== 5'd0) $display("FAIL flush_count: got %0d expected 0", count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL flush_overflow: got %b expected 0", overflow); else n_pass++;
        n_total++; if (out_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", out_ready); else n_pass++;
    endtask

    task automatic test_almost_full();
        for (int i = 0; i < 11; i++) push(8'h60 + 8'(i));
        n_total++; if (almost_full !== 1'b0) $display("FAIL af_11: got %b expected 0", almost_full); else n_pass++;
        push(8'h6B);
        n_total++; if (almost_full !== AF_EN) $display("FAIL af_12: got %b expected %b", almost_full, AF_EN); else n_pass++;
        next = 1'b1;
        tick();
        next = 1'b0;
        n_total++; if (almost_full !== 1'b0) $display("FAIL af_pop: got %b expected 0", almost_full); else n_pass++;
        n_total++; if (out_byte !== 8'h61) $display("FAIL af_head: got %h expected 61", out_byte); else n_pass++;
        do_flush();
    endtask

    initial begin
        reset = 1'b0; rx_byte = '0; rx_valid = 1'b0; flush = 1'b0; next = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_underflow();
        test_wrap_reset();
        test_flush();
        test_almost_full();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cmd_byte_fifo.md
Name: cmd_byte_fifo

Overview:
- Command-byte buffer directly upstream of control_unit; absorbs bursty bytes from the serial receiver (SPI/UART front end) and presents them one at a time on control_unit's in_byte/in_ready/next handshake.
- Show-ahead FIFO: head byte always valid on the output while non-empty; popped by the controller's one-cycle next pulse.
- Reports overflow/underflow and fill level so host-side flow control and debug can detect lost command bytes.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2
- ALMOST_FULL_MARGIN, 4, free-entry threshold for almost_full (optional feature only); 1 .. DEPTH-1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- rx_byte  in  8  byte from serial receiver
- rx_valid  in  1  one-cycle strobe, rx_byte valid this cycle
- flush  in  1  synchronous FIFO clear
- out_byte  out  8  head byte; drives control_unit in_byte
- out_ready  out  1  FIFO non-empty; drives control_unit in_ready
- next  in  1  pop strobe from control_unit
- count  out  $clog2(DEPTH)+1  current fill level
- overflow  out  1  sticky: a byte was dropped
- underflow  out  1  one-cycle pulse: next while empty
- almost_full  out  1  fill level at or above DEPTH-ALMOST_FULL_MARGIN (optional feature)

Behaviour:
- Storage: DEPTH x 8 array; wr_ptr, rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH; count register 0..DEPTH.
- Reset (reset=0, async): wr_ptr=rd_ptr=0, count=0, overflow=0, underflow=0, almost_full=0; out_ready=0. Array contents not reset. out_byte undefined while out_ready=0.
- out_ready = (count != 0); out_byte = array[rd_ptr]; both follow registered state only, never rx_valid/next combinationally.
- Push: rx_valid and (count<DEPTH, or count==DEPTH with accepted pop same cycle) -> write array[wr_ptr], wr_ptr+1.
- Pop: next and count!=0 -> rd_ptr+1. Next byte visible on out_byte the cycle after the pop (matches control_unit's wait_one gap).
- Latency: byte pushed at cycle t is visible on out_byte/out_ready at t+1 when FIFO was empty.
- count: +1 push only, -1 pop only, unchanged for both or neither.
- Full, rx_valid, no pop: byte dropped, state unchanged, overflow<=1 (sticky).
- Full, rx_valid and next: both accepted, count stays DEPTH, no overflow.
- Empty, rx_valid and next: push accepted, pop ignored, count=1, underflow pulses 1 cycle.
- Empty, next only: no state change, underflow pulses 1 cycle.
- flush: next edge wr_ptr=rd_ptr=0, count=0, overflow cleared; rx_valid/next same cycle ignored (flush wins). Control_unit must be in READY or reset for flush to be meaningful; the FIFO does not enforce this.
- underflow defaults to 0 each cycle.
- Reset mid-burst: all pointers cleared immediately; partially-buffered command is discarded; no out_ready glitch after release.

Optional Feature:
- Macro: CMD_FIFO_ALMOST_FULL_EN
- Defined: almost_full registered, = 1 when post-update count >= DEPTH-ALMOST_FULL_MARGIN, else 0; updates same edge as count; cleared by reset/flush. Used as receiver busy/backpressure.
- Not defined: almost_full tied to 0; no compare logic; ALMOST_FULL_MARGIN unused.

Test Plan:
- Reset release, push 0x01 at cycle t -> out_ready=1, out_byte=0x01, count=1 at t+1; next at t+1 -> out_ready=0, count=0 at t+2.
- Push 0x10..0x1F (DEPTH=16) back-to-back, no pops -> count=16, overflow=0; push 0xAA -> overflow=1, count=16; pop all 16 -> bytes 0x10..0x1F in order, 0xAA never appears.
- Full FIFO, rx_valid=1 (0x55) and next=1 same cycle -> count stays 16, overflow=0, 0x55 is the last byte out after draining.
- Empty FIFO, next=1 alone -> underflow single-cycle pulse, count=0; with rx_valid=1 (0x33) same cycle -> count=1, out_byte=0x33, underflow pulses.
- 20 pushes with interleaved pops across pointer wrap; assert reset=0 mid-stream -> count=0, out_ready=0 immediately (async); flush with 5 entries -> count=0, overflow=0 next cycle.
- With CMD_FIFO_ALMOST_FULL_EN, margin 4: 11 pushes -> almost_full=0; 12th -> almost_full=1; one pop -> 0. Without macro -> almost_full=0 throughout.
